// File: rtl/serial_adder_ctrl_pkg.sv
// Shared types for the bit-serial add/subtract controller.
// State encodings are fixed so that the spare code 2'd3 is recognisable as illegal.
package serial_adder_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Bit-counter width; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_fa.sv
// Single full-adder cell shared by every bit position of the serial adder.
module serial_adder_ctrl_fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract controller: one full-adder cell is time-shared across
// all WIDTH bit positions, LSB first, with the carry kept in a flop between bits.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    // Holds the WIDTH-1 most recent sum bits; the bit being produced now completes the word.
    logic [WIDTH-1:1] res;
    logic [WIDTH-1:0] res_full;
    logic             carry;
    logic             cmsb;
    logic [CW-1:0]    cnt;

    logic             fa_s;
    logic             fa_cout;
    logic             accept;
    logic             last_bit;
    logic             msb_in;

    serial_adder_ctrl_fa u_fa (
        .a    (op_a[0]),
        .b    (op_b[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_cout)
    );

    assign accept   = (state == S_IDLE) && start;
    assign last_bit = (cnt == CW'(WIDTH - 1));
    assign msb_in   = (cnt == CW'(WIDTH - 2));
    assign res_full = {fa_s, res};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (last_bit) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            S_RUN:  busy = 1'b1;
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Subtraction is a + ~b + 1, so b is inverted at capture and the carry seeded with 1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_a  <= '0;
            op_b  <= '0;
            res   <= '0;
            carry <= 1'b0;
            cmsb  <= 1'b0;
            cnt   <= '0;
        end else if (accept) begin
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            cnt   <= '0;
        end else if (state == S_RUN) begin
            op_a  <= {1'b0, op_a[WIDTH-1:1]};
            op_b  <= {1'b0, op_b[WIDTH-1:1]};
            res   <= res_full[WIDTH-1:1];
            carry <= fa_cout;
            if (!last_bit) begin
                cnt <= cnt + CW'(1);
            end
            if (msb_in) begin
                cmsb <= fa_cout;
            end
        end
    end

    // Results are loaded on the final bit so they are already visible during DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum  <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
        end else if ((state == S_RUN) && last_bit) begin
            sum  <= res_full;
            cout <= fa_cout;
            ovf  <= cmsb ^ fa_cout;
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: stimulus pushes arithmetic-model results,
// an independent monitor checks busy/done timing and pops results on every done.
module tb_serial_adder_ctrl;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } exp_t;

    exp_t sb_q[$];
    exp_t held;
    int   acc_cyc  = -1;
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   mon_en   = 1'b1;

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Plain integer arithmetic: unsigned result for sum/cout, signed range test for ovf.
    function automatic exp_t refModel(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                      input logic cv, input logic sv);
        exp_t   r;
        longint ua, ub, sa, sb, ru, rs;
        ua = av;
        ub = bv;
        sa = $signed(av);
        sb = $signed(bv);
        if (sv) begin
            ru     = ua - ub;
            rs     = sa - sb;
            r.cout = (ua >= ub);
        end else begin
            ru     = ua + ub + longint'(cv);
            rs     = sa + sb + longint'(cv);
            r.cout = (ru >= (longint'(1) << WIDTH));
        end
        r.sum = WIDTH'(ru);
        r.ovf = (rs > ((longint'(1) << (WIDTH - 1)) - 1)) || (rs < -(longint'(1) << (WIDTH - 1)));
        return r;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Drives start for the next edge; the model decides whether the DUT is idle at that edge.
    task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                 input logic cv, input logic sv);
        a     = av;
        b     = bv;
        cin   = cv;
        sub   = sv;
        start = 1'b1;
        if (acc_cyc < 0 || cyc + 1 >= acc_cyc + WIDTH + 2) begin
            acc_cyc = cyc + 1;
            sb_q.push_back(refModel(av, bv, cv, sv));
        end
        tick(1);
        start = 1'b0;
        a     = WIDTH'($urandom);
        b     = WIDTH'($urandom);
        cin   = 1'($urandom);
        sub   = 1'($urandom);
    endtask

    task automatic waitIdle();
        int guard;
        guard = 0;
        while (!(acc_cyc < 0 || cyc + 1 >= acc_cyc + WIDTH + 2)) begin
            tick(1);
            guard++;
            if (guard > 4 * WIDTH) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL idle_timeout: still waiting after %0d cycles, required at most %0d", guard, 4 * WIDTH);
                break;
            end
        end
    endtask

    always @(negedge clk) begin : monitor
        logic exp_busy;
        logic exp_done;
        exp_t e;
        if (mon_en) begin
            exp_busy = (acc_cyc >= 0) && (cyc >= acc_cyc) && (cyc <= acc_cyc + WIDTH);
            exp_done = (acc_cyc >= 0) && (cyc == acc_cyc + WIDTH);
            checkOutput("busy", 32'(busy), 32'(exp_busy));
            checkOutput("done", 32'(done), 32'(exp_done));
            if (done || exp_done) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL scoreboard: done seen with empty queue, sum=%0h", sum);
                end else begin
                    e    = sb_q.pop_front();
                    held = e;
                    checkOutput("sum", 32'(sum), 32'(e.sum));
                    checkOutput("cout", 32'(cout), 32'(e.cout));
                    checkOutput("ovf", 32'(ovf), 32'(e.ovf));
                end
            end else begin
                checkOutput("held_sum", 32'(sum), 32'(held.sum));
                checkOutput("held_cout", 32'(cout), 32'(held.cout));
                checkOutput("held_ovf", 32'(ovf), 32'(held.ovf));
            end
        end
    end

    initial begin
        held.sum  = '0;
        held.cout = 1'b0;
        held.ovf  = 1'b0;
        rst_n = 1'b0;
        start = 1'b0;
        sub   = 1'b0;
        cin   = 1'b0;
        a     = '0;
        b     = '0;
        tick(2);
        rst_n = 1'b1;

        $display("[TB] directed add/sub cases");
        applyStimulus(8'h25, 8'h1A, 1'b0, 1'b0);
        waitIdle();
        applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0);
        waitIdle();
        applyStimulus(8'hFF, 8'h01, 1'b1, 1'b0);
        waitIdle();
        applyStimulus(8'h7F, 8'h01, 1'b0, 1'b0);
        waitIdle();
        applyStimulus(8'h10, 8'h01, 1'b0, 1'b1);
        waitIdle();

        $display("[TB] start while busy, then back-to-back start");
        applyStimulus(8'h01, 8'h01, 1'b0, 1'b0);
        tick(2);
        applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0);
        waitIdle();
        applyStimulus(8'h33, 8'h44, 1'b1, 1'b0);
        waitIdle();

        $display("[TB] reset in the middle of an operation");
        applyStimulus(8'hA5, 8'h5A, 1'b1, 1'b0);
        tick(3);
        rst_n = 1'b0;
        tick(1);
        acc_cyc = -1;
        sb_q.delete();
        held.sum  = '0;
        held.cout = 1'b0;
        held.ovf  = 1'b0;
        rst_n = 1'b1;
        tick(1);
        applyStimulus(8'h80, 8'h80, 1'b0, 1'b0);
        waitIdle();

        $display("[TB] randomised operations");
        for (int i = 0; i < 200; i++) begin
            waitIdle();
            tick($urandom_range(0, 2));
            applyStimulus(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                tick($urandom_range(1, WIDTH - 1));
                applyStimulus(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom));
            end
        end
        waitIdle();
        tick(WIDTH + 3);
        checkOutput("pending", 32'(sb_q.size()), 32'd0);
        mon_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
